// File: rtl/sdram_probe_pkg.sv
// Shared types and constants for the SDRAM module-size probe and port arbiter.
package sdram_probe_pkg;

    localparam int unsigned AW = 27;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned SW = 3;

    typedef enum logic [2:0] {
        P_WAITRDY,
        P_CMD,
        P_BLIND,
        P_WAIT,
        ARB,
        A_CMD,
        A_BLIND,
        A_WAIT
    } state_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } cmd_t;

    localparam logic [AW-1:0] A_HI  = 27'h4000000;
    localparam logic [AW-1:0] A_MID = 27'h2000000;
    localparam logic [AW-1:0] A_LO  = 27'h0000000;
    localparam logic [AW-1:0] A_CLB = 27'h1000000;

    localparam logic [DW-1:0] DEF_SIG_HI  = 16'd3128;
    localparam logic [DW-1:0] DEF_SIG_MID = 16'd2064;
    localparam logic [DW-1:0] DEF_SIG_LO  = 16'd1032;
    localparam logic [DW-1:0] DEF_SIG_CLB = 16'd12345;
    localparam int unsigned   DEF_TIMEOUT = 1024;

    // Probe steps 0..3 are writes (HI, MID, LO, CLB), 4..6 are reads (HI, MID, LO).
    localparam logic [SW-1:0] STEP_FIRST_RD = 3'd4;
    localparam logic [SW-1:0] STEP_LAST     = 3'd6;

    function automatic logic [AW-1:0] step_addr(input logic [SW-1:0] step);
        case (step)
            3'd0, 3'd4: return A_HI;
            3'd1, 3'd5: return A_MID;
            3'd3:       return A_CLB;
            default:    return A_LO;
        endcase
    endfunction

endpackage

// File: rtl/sdram_rr_arb2.sv
// Two-way round-robin grant: combinational grant, registered fairness pointer.
module sdram_rr_arb2 (
    input  logic clk_sys,
    input  logic RESET,
    input  logic req0,
    input  logic req1,
    output logic gnt_c,
    output logic gnt_port_c
);

    logic rr_q;
    logic rr_d;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        gnt_c      = req0 | req1;
        gnt_port_c = (req0 && req1) ? rr_q : req1;
        rr_d       = rr_q;
        if (gnt_c) begin
            rr_d = ~gnt_port_c;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/sdram_probe_arb.sv
// Post-reset SDRAM size probe followed by round-robin sharing of the controller
// between the RAM clear engine (port 0) and the test/debug port (port 1).
module sdram_probe_arb
    import sdram_probe_pkg::*;
#(
    parameter logic [DW-1:0] SIG_HI  = DEF_SIG_HI,
    parameter logic [DW-1:0] SIG_MID = DEF_SIG_MID,
    parameter logic [DW-1:0] SIG_LO  = DEF_SIG_LO,
    parameter logic [DW-1:0] SIG_CLB = DEF_SIG_CLB,
    parameter int unsigned   TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk_sys,
    input  logic          RESET,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ready,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_din,
    output logic          p0_ack,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_din,
    output logic          p1_ack,
    output logic          p1_rvalid,
    output logic [DW-1:0] rdata,
    output logic [2:0]    size_cfg,
    output logic          probe_done,
    output logic          probe_err,
    output logic          busy
);

    localparam logic [CW-1:0] TO_LAST = 16'(TIMEOUT - 32'd1);

    state_e        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_rd_q, mem_rd_d;
    logic          p0_ack_q, p0_ack_d;
    logic          p1_ack_q, p1_ack_d;
    logic          p0_rvalid_q, p0_rvalid_d;
    logic          p1_rvalid_q, p1_rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    size_cfg_q, size_cfg_d;
    logic          probe_done_q, probe_done_d;
    logic          probe_err_q, probe_err_d;
    logic          busy_q, busy_d;
    logic          owner_q, owner_d;
    logic          is_rd_q, is_rd_d;

    logic          arb_en;
    logic          gnt_c;
    logic          gnt_port_c;
    logic          issue;
    logic          abort;
    cmd_t          p0_cmd, p1_cmd, sel_cmd;

    function automatic logic [DW-1:0] step_sig(input logic [SW-1:0] step);
        case (step)
            3'd0, 3'd4: return SIG_HI;
            3'd1, 3'd5: return SIG_MID;
            3'd3:       return SIG_CLB;
            default:    return SIG_LO;
        endcase
    endfunction

    assign arb_en  = (state_q == ARB) && mem_ready;
    assign p0_cmd  = {p0_we, p0_addr, p0_din};
    assign p1_cmd  = {p1_we, p1_addr, p1_din};
    assign sel_cmd = gnt_port_c ? p1_cmd : p0_cmd;

    sdram_rr_arb2 u_arb (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .req0       (p0_req && arb_en),
        .req1       (p1_req && arb_en),
        .gnt_c      (gnt_c),
        .gnt_port_c (gnt_port_c)
    );

    // Sequencer: probe steps, then arbitration; each command is pulse, blind, wait.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = 1'b0;
        mem_rd_d     = 1'b0;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_rvalid_d  = 1'b0;
        p1_rvalid_d  = 1'b0;
        rdata_d      = rdata_q;
        size_cfg_d   = size_cfg_q;
        probe_done_d = probe_done_q;
        probe_err_d  = probe_err_q;
        busy_d       = busy_q;
        owner_d      = owner_q;
        is_rd_d      = is_rd_q;
        issue        = 1'b0;
        abort        = 1'b0;

        case (state_q)
            P_WAITRDY: begin
                if (mem_ready) begin
                    issue  = 1'b1;
                    step_d = 3'd0;
                end else if (cnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            P_CMD:   state_d = P_BLIND;
            P_BLIND: state_d = P_WAIT;
            P_WAIT: begin
                if (mem_ready) begin
                    if (step_q >= STEP_FIRST_RD) begin
                        rdata_d = mem_dout;
                    end
                    case (step_q)
                        3'd4:    size_cfg_d[2] = (mem_dout == SIG_HI);
                        3'd5:    size_cfg_d[1] = (mem_dout == SIG_MID);
                        3'd6:    size_cfg_d[0] = (mem_dout == SIG_LO);
                        default: ;
                    endcase
                    if (step_q == STEP_LAST) begin
                        probe_done_d = 1'b1;
                        state_d      = ARB;
                    end else begin
                        issue  = 1'b1;
                        step_d = step_q + 3'd1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ARB: begin
                if (gnt_c) begin
                    mem_addr_d = sel_cmd.addr;
                    mem_din_d  = sel_cmd.din;
                    mem_we_d   = sel_cmd.we;
                    mem_rd_d   = ~sel_cmd.we;
                    p0_ack_d   = ~gnt_port_c;
                    p1_ack_d   = gnt_port_c;
                    owner_d    = gnt_port_c;
                    is_rd_d    = ~sel_cmd.we;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = A_CMD;
                end
            end
            A_CMD:   state_d = A_BLIND;
            A_BLIND: state_d = A_WAIT;
            A_WAIT: begin
                // No timeout here: a slow controller simply stalls the ports.
                if (mem_ready) begin
                    if (is_rd_q) begin
                        rdata_d     = mem_dout;
                        p0_rvalid_d = ~owner_q;
                        p1_rvalid_d = owner_q;
                    end
                    busy_d  = 1'b0;
                    state_d = ARB;
                end
            end
            default: state_d = P_WAITRDY;
        endcase

        if (issue) begin
            state_d    = P_CMD;
            cnt_d      = '0;
            mem_addr_d = step_addr(step_d);
            mem_din_d  = step_sig(step_d);
            mem_we_d   = (step_d < STEP_FIRST_RD);
            mem_rd_d   = (step_d >= STEP_FIRST_RD);
        end

        if (abort) begin
            size_cfg_d   = '0;
            probe_err_d  = 1'b1;
            probe_done_d = 1'b1;
            state_d      = ARB;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q      <= P_WAITRDY;
            step_q       <= '0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_rvalid_q  <= 1'b0;
            p1_rvalid_q  <= 1'b0;
            rdata_q      <= '0;
            size_cfg_q   <= '0;
            probe_done_q <= 1'b0;
            probe_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            owner_q      <= 1'b0;
            is_rd_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
            mem_rd_q     <= mem_rd_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_rvalid_q  <= p0_rvalid_d;
            p1_rvalid_q  <= p1_rvalid_d;
            rdata_q      <= rdata_d;
            size_cfg_q   <= size_cfg_d;
            probe_done_q <= probe_done_d;
            probe_err_q  <= probe_err_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            is_rd_q      <= is_rd_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_we     = mem_we_q;
    assign mem_rd     = mem_rd_q;
    assign p0_ack     = p0_ack_q;
    assign p1_ack     = p1_ack_q;
    assign p0_rvalid  = p0_rvalid_q;
    assign p1_rvalid  = p1_rvalid_q;
    assign rdata      = rdata_q;
    assign size_cfg   = size_cfg_q;
    assign probe_done = probe_done_q;
    assign probe_err  = probe_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sdram_probe_arb.sv
// Scoreboard bench for sdram_probe_arb against an aliasing SDRAM word model.
module tb_sdram_probe_arb;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic [26:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we, mem_rd;
    logic [15:0] mem_dout = 16'h0;
    logic        mem_ready;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [26:0] p0_addr = '0, p1_addr = '0;
    logic [15:0] p0_din = '0, p1_din = '0;
    logic        p0_ack, p1_ack, p0_rvalid, p1_rvalid;
    logic [15:0] rdata;
    logic [2:0]  size_cfg;
    logic        probe_done, probe_err, busy;

    sdram_probe_arb dut (
        .clk_sys(clk_sys), .RESET(RESET),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
        .p0_ack(p0_ack), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_ack(p1_ack), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .size_cfg(size_cfg), .probe_done(probe_done),
        .probe_err(probe_err), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SDRAM word model: address masked to emulate smaller modules, 3 busy cycles per command.
    logic [15:0] mem [logic [26:0]];
    logic [26:0] mdl_mask = 27'h7FFFFFF;
    logic        stall    = 1'b0;
    int          mdl_busy = 0;

    function automatic logic [15:0] mdl_rd(input logic [26:0] a);
        logic [26:0] m;
        m = a & mdl_mask;
        if (mem.exists(m)) return mem[m];
        return m[15:0] ^ 16'hA5A5;
    endfunction

    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr & mdl_mask] = mem_din;
        if (mem_we || mem_rd) begin
            mdl_busy <= 2;
            mem_dout <= mdl_rd(mem_addr);
        end else if (mdl_busy != 0) begin
            mdl_busy <= mdl_busy - 1;
        end
    end

    assign mem_ready = !stall && (mdl_busy == 0);

    // Scoreboards: expected probe commands and per-port read data.
    logic [27:0] exp_cmd [$];
    logic [15:0] exp_rd0 [$];
    logic [15:0] exp_rd1 [$];
    bit          ack_log [$];
    int          ack0_cnt = 0, ack1_cnt = 0, rv0_cnt = 0, rv1_cnt = 0;
    int          last_ack = -1;

    always @(negedge clk_sys) begin
        if ((mem_we || mem_rd) && !probe_done && !p0_ack && !p1_ack) begin
            if (exp_cmd.size() == 0) chk("probe_cmd_extra", 64'({mem_we, mem_addr}), 64'h0);
            else chk("probe_cmd", 64'({mem_we, mem_addr}), 64'(exp_cmd.pop_front()));
        end
        if (p0_ack || p1_ack) begin
            chk("ack_probe_done", 64'(probe_done), 64'd1);
            chk("ack_with_cmd", 64'(mem_we ^ mem_rd), 64'd1);
            chk("ack_exclusive", 64'(p0_ack & p1_ack), 64'd0);
            chk("ack_busy", 64'(busy), 64'd1);
            if (last_ack >= 0) chk("ack_gap", 64'((cyc - last_ack) >= 3), 64'd1);
            last_ack = cyc;
            if (p0_ack) begin
                ack0_cnt++;
                ack_log.push_back(1'b0);
                chk("ack0_addr", 64'(mem_addr), 64'(p0_addr));
                if (!p0_we) exp_rd0.push_back(mdl_rd(p0_addr));
            end
            if (p1_ack) begin
                ack1_cnt++;
                ack_log.push_back(1'b1);
                chk("ack1_addr", 64'(mem_addr), 64'(p1_addr));
                if (!p1_we) exp_rd1.push_back(mdl_rd(p1_addr));
            end
        end
        if (p0_rvalid) begin
            rv0_cnt++;
            if (exp_rd0.size() == 0) chk("rv0_unexpected", 64'd1, 64'd0);
            else chk("rv0_data", 64'(rdata), 64'(exp_rd0.pop_front()));
        end
        if (p1_rvalid) begin
            rv1_cnt++;
            if (exp_rd1.size() == 0) chk("rv1_unexpected", 64'd1, 64'd0);
            else chk("rv1_data", 64'(rdata), 64'(exp_rd1.pop_front()));
        end
    end

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_ctl"}, 64'({mem_din, rdata, mem_we, mem_rd, p0_ack, p1_ack,
                                p0_rvalid, p1_rvalid, size_cfg, probe_done, probe_err, busy}),
            64'd0);
    endtask

    // Holds RESET, selects the module size and queues the expected probe command order.
    task automatic start_probe(input logic [26:0] mask, input string tag);
        logic [27:0] seq [7];
        seq = '{{1'b1, 27'h4000000}, {1'b1, 27'h2000000}, {1'b1, 27'h0000000},
                {1'b1, 27'h1000000}, {1'b0, 27'h4000000}, {1'b0, 27'h2000000},
                {1'b0, 27'h0000000}};
        RESET = 1'b1;
        repeat (3) @(posedge clk_sys);
        mdl_mask = mask;
        exp_cmd.delete();
        exp_rd0.delete();
        exp_rd1.delete();
        for (int i = 0; i < 7; i++) exp_cmd.push_back(seq[i]);
        @(negedge clk_sys);
        chk_rst_outs(tag);
    endtask

    task automatic wait_done(input int lim, input string tag);
        int n;
        n = 0;
        while (!probe_done && n < lim) begin
            @(negedge clk_sys);
            n++;
        end
        chk(tag, 64'(probe_done), 64'd1);
    endtask

    initial begin
        int n;
        int c0;

        // Full-size module with a debug write pending throughout the probe.
        start_probe(27'h7FFFFFF, "rst0");
        p1_we   = 1'b1;
        p1_addr = 27'h123;
        p1_din  = 16'hBEEF;
        p1_req  = 1'b1;
        RESET   = 1'b0;
        wait_done(2000, "t1_done");
        chk("t1_cfg", 64'(size_cfg), 64'h7);
        chk("t1_err", 64'(probe_err), 64'd0);
        chk("t1_cmds_left", 64'(exp_cmd.size()), 64'd0);
        n = 0;
        while (!p1_ack && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t5_ack", 64'(p1_ack), 64'd1);
        p1_req = 1'b0;
        repeat (12) @(negedge clk_sys);
        chk("t5_mem", 64'(mdl_rd(27'h123)), 64'hBEEF);
        chk("t5_no_rvalid", 64'(rv1_cnt), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);

        // Both ports streaming reads: grants must alternate starting with p0.
        ack_log.delete();
        rv0_cnt = 0;
        rv1_cnt = 0;
        p0_we = 1'b0; p0_addr = 27'd5;
        p1_we = 1'b0; p1_addr = 27'd9;
        p0_req = 1'b1; p1_req = 1'b1;
        n = 0;
        while (ack_log.size() < 6 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("t4_nacks", 64'(ack_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < ack_log.size(); i++)
            chk("t4_order", 64'(ack_log[i]), 64'(i % 2));
        repeat (15) @(negedge clk_sys);
        chk("t4_rv0_cnt", 64'(rv0_cnt), 64'd3);
        chk("t4_rv1_cnt", 64'(rv1_cnt), 64'd3);
        chk("t4_sb_empty", 64'(exp_rd0.size() + exp_rd1.size()), 64'd0);

        // Smaller modules alias the upper addresses.
        start_probe(27'h0FFFFFF, "rst32");
        RESET = 1'b0;
        wait_done(2000, "t2a_done");
        chk("t2a_cfg", 64'(size_cfg), 64'h0);
        chk("t2a_err", 64'(probe_err), 64'd0);
        start_probe(27'h1FFFFFF, "rst64");
        RESET = 1'b0;
        wait_done(2000, "t2b_done");
        chk("t2b_cfg", 64'(size_cfg), 64'h1);
        chk("t2b_err", 64'(probe_err), 64'd0);

        // Controller stalls after the first probe write.
        start_probe(27'h7FFFFFF, "rst_to");
        RESET = 1'b0;
        n = 0;
        while (!mem_we && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t3_first_wr", 64'(mem_we), 64'd1);
        c0 = cyc;
        stall = 1'b1;
        @(posedge clk_sys);
        exp_cmd.delete();
        wait_done(1200, "t3_done");
        chk("t3_latency", 64'((cyc - c0) >= 1024 && (cyc - c0) <= 1030), 64'd1);
        chk("t3_err", 64'(probe_err), 64'd1);
        chk("t3_cfg", 64'(size_cfg), 64'h0);
        stall = 1'b0;

        // Reset during the blind cycle of a p0 read abandons it and restarts the probe.
        start_probe(27'h7FFFFFF, "rst6a");
        RESET = 1'b0;
        wait_done(2000, "t6_pre_done");
        rv0_cnt = 0;
        p0_we = 1'b0; p0_addr = 27'd5; p0_req = 1'b1;
        n = 0;
        while (!p0_ack && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t6_ack", 64'(p0_ack), 64'd1);
        p0_req = 1'b0;
        @(posedge clk_sys);
        #1 RESET = 1'b1;
        exp_rd0.delete();
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk_rst_outs("t6_rst");
        repeat (5) @(negedge clk_sys);
        chk("t6_no_rvalid", 64'(rv0_cnt), 64'd0);
        start_probe(27'h7FFFFFF, "rst6b");
        RESET = 1'b0;
        wait_done(2000, "t6_done");
        chk("t6_cfg", 64'(size_cfg), 64'h7);
        chk("t6_cmds_left", 64'(exp_cmd.size()), 64'd0);
        chk("t6_rv_after", 64'(rv0_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
